// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: frame FSM states, UART receiver bit
// states and the default frame header byte.
package boot_loader_pkg;

  // Frame-level FSM states.
  typedef enum logic [2:0] {
    StHunt,
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  // UART receiver bit-level states.
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/boot_loader_uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last received byte (LSB first on the line)
//   byte_valid out  one-cycle pulse when a byte ends with a good stop bit
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
module uart_rx
  import boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  rx_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_byte_valid;
  logic            r_frame_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_state      <= RxIdle;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= rx;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RxIdle: begin
          // True falling edge only, so a line stuck low after a bad stop bit
          // does not retrigger endlessly.
          if (r_prev && !r_sync2) begin
            r_state <= RxStart;
            r_cnt   <= '0;
          end
        end
        RxStart: begin
          if (r_cnt == CntHalf) begin
            r_cnt <= '0;
            r_bit <= '0;
            // High at mid start bit means a glitch, not a frame.
            r_state <= r_sync2 ? RxIdle : RxData;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        RxData: begin
          if (r_cnt == CntFull) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RxStop;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        RxStop: begin
          if (r_cnt == CntFull) begin
            r_cnt        <= '0;
            r_state      <= RxIdle;
            r_byte_valid <= r_sync2;
            r_frame_err  <= ~r_sync2;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        default: r_state <= RxIdle;
      endcase
    end
  end

  assign data       = r_shift;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a program image over UART and writes it into the
// program RAM write port while holding the CPU in reset.
// Frame: SYNC, LEN_HI, LEN_LO, 4*N data bytes (big-endian words), CSUM (XOR of
// data bytes).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   rx         in   UART serial input, 8N1
//   ram_we     out  byte write enables, 4'hF for one cycle per word
//   ram_addr   out  RAM word address
//   ram_wdata  out  RAM write data
//   cpu_reset  out  CPU reset, released only after a verified load
//   busy       out  load in progress
//   done       out  sticky load-complete flag
//   error      out  framing, length or checksum fault
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 9,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned MaxWords = 1 << ADDR_W;
  localparam logic [ADDR_W:0] IdxOne = (ADDR_W + 1)'(1);

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_frame_err;
  logic [15:0] w_len_full;
  logic [31:0] w_word;

  state_e            r_state;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  // One bit wider than the address so N = 2**ADDR_W does not wrap.
  logic [ADDR_W:0]   r_idx;
  logic [23:0]       r_buf;
  logic [1:0]        r_bcnt;
  logic [7:0]        r_csum;
  logic [3:0]        r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (w_byte),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err)
  );

  assign w_len_full = {r_len_hi, w_byte};
  assign w_word     = {r_buf, w_byte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StHunt;
      r_len_hi    <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_buf       <= '0;
      r_bcnt      <= '0;
      r_csum      <= '0;
      r_ram_we    <= 4'h0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_ram_we <= 4'h0;
      if (w_frame_err) begin
        // Bad stop bit aborts an active or failed load; HUNT and DONE ignore it.
        if (r_state != StHunt && r_state != StDone) begin
          r_state <= StError;
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end
      end else if (w_byte_valid) begin
        case (r_state)
          StHunt, StError: begin
            if (w_byte == SYNC_BYTE) begin
              r_state <= StLenHi;
              r_error <= 1'b0;
              r_busy  <= 1'b1;
              r_idx   <= '0;
              r_bcnt  <= '0;
              r_csum  <= '0;
            end
          end
          StLenHi: begin
            r_len_hi <= w_byte;
            r_state  <= StLenLo;
          end
          StLenLo: begin
            r_len <= w_len_full;
            if (32'(w_len_full) > MaxWords) begin
              r_state <= StError;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_len_full == 16'd0) begin
              r_state <= StCsum;
            end else begin
              r_state <= StData;
            end
          end
          StData: begin
            r_buf  <= w_word[23:0];
            r_csum <= r_csum ^ w_byte;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_ram_we    <= 4'hF;
              r_ram_addr  <= r_idx[ADDR_W-1:0];
              r_ram_wdata <= w_word;
              r_idx       <= r_idx + IdxOne;
              if (32'(r_idx) + 32'd1 == 32'(r_len)) r_state <= StCsum;
            end
          end
          StCsum: begin
            r_busy <= 1'b0;
            if (w_byte == r_csum) begin
              r_state     <= StDone;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= StError;
              r_error <= 1'b1;
            end
          end
          default: ;  // StDone: ignore traffic until reset
        endcase
      end
    end
  end

  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader. A main instance (ADDR_W=9) covers the frame
// behaviour; a small instance (ADDR_W=2) covers a completely full RAM.
// Expected RAM writes are queued by the stimulus and popped by per-instance
// monitors whenever ram_we is seen.
module tb_boot_loader;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  logic sel_small = 1'b0;
  logic rx_main;
  logic rx_small;

  assign rx_main  = sel_small ? 1'b1 : line;
  assign rx_small = sel_small ? line : 1'b1;

  logic [3:0]  m_we;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_cpu_reset, m_busy, m_done, m_error;

  logic [3:0]  s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_cpu_reset, s_busy, s_done, s_error;

  boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (9),
    .SYNC_BYTE   (8'hA5)
  ) u_dut (
    .clk      (clk),
    .reset    (rst_n),
    .rx       (rx_main),
    .ram_we   (m_we),
    .ram_addr (m_addr),
    .ram_wdata(m_wdata),
    .cpu_reset(m_cpu_reset),
    .busy     (m_busy),
    .done     (m_done),
    .error    (m_error)
  );

  boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (2),
    .SYNC_BYTE   (8'hA5)
  ) u_dut_small (
    .clk      (clk),
    .reset    (rst_n),
    .rx       (rx_small),
    .ram_we   (s_we),
    .ram_addr (s_addr),
    .ram_wdata(s_wdata),
    .cpu_reset(s_cpu_reset),
    .busy     (s_busy),
    .done     (s_done),
    .error    (s_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t q_main[$];
  wr_t q_small[$];

  int checks = 0;
  int failures = 0;

  // Data bytes of the reference two-word image; their XOR is 8'h2A.
  logic [7:0] img[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_main(input int unsigned a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    q_main.push_back(w);
  endtask

  task automatic exp_small(input int unsigned a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    q_small.push_back(w);
  endtask

  // Write monitors: every ram_we cycle must match the next queued write.
  always @(negedge clk) begin
    if (m_we != 4'h0) begin
      if (q_main.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_unexpected_write actual addr=%0d data=%h required none",
                 m_addr, m_wdata);
      end else begin
        wr_t e;
        e = q_main.pop_front();
        check("main_we", 32'(m_we), 32'hF);
        check("main_addr", 32'(m_addr), e.addr);
        check("main_wdata", m_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (s_we != 4'h0) begin
      if (q_small.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL small_unexpected_write actual addr=%0d data=%h required none",
                 s_addr, s_wdata);
      end else begin
        wr_t e;
        e = q_small.pop_front();
        check("small_we", 32'(s_we), 32'hF);
        check("small_addr", 32'(s_addr), e.addr);
        check("small_wdata", s_wdata, e.data);
      end
    end
  end

  // 8N1 byte, LSB first, followed by one idle bit time; starts and ends on negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop_bit;
    repeat (CPB) @(negedge clk);
    line = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] csum_flip);
    logic [7:0] cs;
    cs = 8'h00;
    exp_main(0, 32'h12345678);
    exp_main(1, 32'hDEADBEEF);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i]);
      cs = cs ^ img[i];
    end
    send_byte(cs ^ csum_flip);
  endtask

  task automatic status(input string tag, input logic b, input logic d, input logic e,
                        input logic c);
    check({tag, "_busy"}, 32'(m_busy), 32'(b));
    check({tag, "_done"}, 32'(m_done), 32'(d));
    check({tag, "_error"}, 32'(m_error), 32'(e));
    check({tag, "_cpu_reset"}, 32'(m_cpu_reset), 32'(c));
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_we"}, 32'(m_we), 32'h0);
    check({tag, "_addr"}, 32'(m_addr), 32'h0);
    check({tag, "_wdata"}, m_wdata, 32'h0);
    status(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] cs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_values("por");
    check("por_small_cpu_reset", 32'(s_cpu_reset), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Good load, then later traffic is ignored.
    send_good(8'h00);
    status("good", 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    status("after_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bad checksum: words still land, load fails.
    do_reset();
    send_good(8'h01);
    status("bad_csum", 1'b0, 1'b0, 1'b1, 1'b1);

    // Restart from ERROR.
    send_good(8'h00);
    status("restart", 1'b0, 1'b1, 1'b0, 1'b0);

    // Leading junk in HUNT is ignored.
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    status("hunt_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    send_good(8'h00);
    status("hunt", 1'b0, 1'b1, 1'b0, 1'b0);

    // Framing fault on the 2nd data byte; the first word is never completed.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56);
    send_byte(8'h78);
    status("framing", 1'b0, 1'b0, 1'b1, 1'b1);

    // Length one beyond capacity.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    status("len_over", 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    status("len_over_data", 1'b0, 1'b0, 1'b1, 1'b1);

    // Length exactly at capacity is accepted.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    status("len_max", 1'b1, 1'b0, 1'b0, 1'b1);

    // Empty image.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    status("len_zero", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset after 6 data bytes, then a clean load from address 0.
    do_reset();
    exp_main(0, 32'h12345678);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    status("mid_load", 1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    reset_values("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    send_good(8'h00);
    status("after_rst", 1'b0, 1'b1, 1'b0, 1'b0);

    // Small instance: full RAM of 4 words, last write at address 3.
    do_reset();
    sel_small = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h04);
    cs = 8'h00;
    for (int k = 0; k < 4; k++) begin
      exp_small(k, {8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3), 8'(4 * k + 4)});
    end
    for (int i = 1; i <= 16; i++) begin
      send_byte(8'(i));
      cs = cs ^ 8'(i);
    end
    send_byte(cs);
    check("small_full_done", 32'(s_done), 32'h1);
    check("small_full_cpu_reset", 32'(s_cpu_reset), 32'h0);
    check("small_full_error", 32'(s_error), 32'h0);

    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h05);
    check("small_over_error", 32'(s_error), 32'h1);
    check("small_over_cpu_reset", 32'(s_cpu_reset), 32'h1);
    sel_small = 1'b0;

    repeat (4) @(negedge clk);
    check("main_pending_writes", q_main.size(), 32'h0);
    check("small_pending_writes", q_small.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
